// File: rtl/pipeline_barrier_if.sv
// Handshake bundle for pipeline_barrier: the upstream and downstream valid/ready/data pairs plus flush.
// The slave modport is the barrier's view of the bundle; the master modport is the surrounding pipeline's view.
interface pipeline_barrier_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/pipeline_barrier.sv
// Two-entry skid buffer between pipeline stages, with a registered in_ready and flush support.
// Defining PIPELINE_BARRIER_STATS_EN adds a saturating 16-bit stall_count output.
module pipeline_barrier #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_barrier_if.slave    bus
`ifdef PIPELINE_BARRIER_STATS_EN
    ,
    output logic [15:0]          stall_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             in_ready_q;
    logic             out_valid_w;
    logic             in_fire;
    logic             out_fire;

    assign out_valid_w   = (state_q != EMPTY);
    assign in_fire       = bus.in_valid && in_ready_q;
    assign out_fire      = out_valid_w && bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_valid_w ? main_q : NOP_VALUE;

    // Next-state and storage update; main always holds the oldest payload, so it feeds out_data directly.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = bus.in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_d  = bus.in_data;
                        state_d = TWO;
                    end else if (in_fire && out_fire) begin
                        main_d  = bus.in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // in_ready is derived from the next state so it never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
        end
    end

`ifdef PIPELINE_BARRIER_STATS_EN
    logic [15:0] stall_q;

    // Counts edges where downstream refused a valid payload; a flush edge is not a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if (out_valid_w && !bus.out_ready && !bus.flush && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_barrier.sv
// Directed-vector bench for pipeline_barrier; stats checks compile in when PIPELINE_BARRIER_STATS_EN is defined.
module tb_pipeline_barrier;

    localparam logic [15:0] NOP = 16'h0BAD;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    pipeline_barrier_if #(.WIDTH(16)) bus ();

`ifdef PIPELINE_BARRIER_STATS_EN
    logic [15:0] stall_count;
`endif

    pipeline_barrier #(
        .WIDTH     (16),
        .NOP_VALUE (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave)
`ifdef PIPELINE_BARRIER_STATS_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkPort(input string tag, input logic valid, input logic [15:0] data, input logic ready);
        checkOutput({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, valid});
        checkOutput({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, data});
        checkOutput({tag, "_ready"}, {31'd0, bus.in_ready}, {31'd0, ready});
    endtask

    // Drive one cycle of inputs, take the rising edge, then settle before any sampling.
    task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic ready, input logic fl);
        bus.in_valid  = valid;
        bus.in_data   = data;
        bus.out_ready = ready;
        bus.flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        #2 rst_n = 1'b0;
        #1 checkPort("reset", 1'b0, NOP, 1'b1);
`ifdef PIPELINE_BARRIER_STATS_EN
        checkOutput("reset_stall", {16'd0, stall_count}, 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-rate stream
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0);
            checkPort($sformatf("stream%0d", i), 1'b1, 16'h1000 + 16'(i), 1'b1);
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkPort("stream_drain", 1'b0, NOP, 1'b1);

        // Backpressure into TWO, then drain in order
        applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
        checkPort("bp_one", 1'b1, 16'hAAAA, 1'b1);
        applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b0);
        checkPort("bp_two", 1'b1, 16'hAAAA, 1'b0);
        applyStimulus(1'b1, 16'hDDDD, 1'b0, 1'b0);
        checkPort("bp_hold", 1'b1, 16'hAAAA, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkPort("bp_out1", 1'b1, 16'hBBBB, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkPort("bp_out2", 1'b0, NOP, 1'b1);

        // Simultaneous in/out while ONE
        applyStimulus(1'b1, 16'h1111, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h2222, 1'b1, 1'b0);
        checkPort("passthru", 1'b1, 16'h2222, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkPort("passthru_drain", 1'b0, NOP, 1'b1);

        // Flush from TWO with a competing input
        applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hCCCC, 1'b0, 1'b1);
        checkPort("flush_two", 1'b0, NOP, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkPort("flush_after", 1'b0, NOP, 1'b1);

        // Flush from ONE beats a same-cycle accept and output
        applyStimulus(1'b1, 16'h3333, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h4444, 1'b1, 1'b1);
        checkPort("flush_one", 1'b0, NOP, 1'b1);

        // Asynchronous reset while ONE, held across an edge with input offered
        applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
        checkPort("pre_reset", 1'b1, 16'h5555, 1'b1);
        #3 rst_n = 1'b0;
        #1 checkPort("async_reset", 1'b0, NOP, 1'b1);
        applyStimulus(1'b1, 16'h6666, 1'b1, 1'b0);
        checkPort("reset_held", 1'b0, NOP, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h0042, 1'b1, 1'b0);
        checkPort("post_reset", 1'b1, 16'h0042, 1'b1);

`ifdef PIPELINE_BARRIER_STATS_EN
        checkOutput("stall_zero", {16'd0, stall_count}, 32'd0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("stall_one", {16'd0, stall_count}, 32'd1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("stall_flush", {16'd0, stall_count}, 32'd1);
        applyStimulus(1'b1, 16'h9999, 1'b0, 1'b0);
        checkOutput("stall_empty", {16'd0, stall_count}, 32'd1);
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        end
        checkOutput("stall_sat", {16'd0, stall_count}, 32'h0000FFFF);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("stall_nowrap", {16'd0, stall_count}, 32'h0000FFFF);
        checkPort("stall_hold", 1'b1, 16'h9999, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkPort("stall_drain", 1'b0, NOP, 1'b1);
        checkOutput("stall_sat_kept", {16'd0, stall_count}, 32'h0000FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_barrier.md
PIPELINE_BARRIER -- requirements
Module: pipeline_barrier

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the payload width in bits (one lc3b_word).
REQ-002 The module SHALL have parameter NOP_VALUE, default 0, of WIDTH bits, driven on out_data whenever the barrier holds no valid entry.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream stage presents a payload.
REQ-007 in_ready  output  1  barrier can accept a payload this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  barrier presents a payload downstream.
REQ-010 out_ready  input  1  downstream stage consumes the payload this cycle.
REQ-011 out_data  output  WIDTH  downstream payload.
REQ-012 flush  input  1  squashes all held payloads (branch mispredict, trap).
REQ-013 stall_count  output  16  saturating stall counter; present only with PIPELINE_BARRIER_STATS_EN.

Function
REQ-014 A transfer in SHALL occur on a rising edge with in_valid && in_ready; a transfer out SHALL occur with out_valid && out_ready.
REQ-015 Storage SHALL be two WIDTH-bit registers, main and skid, tracked by states EMPTY (none held), ONE (main held) and TWO (main and skid held).
REQ-016 out_valid SHALL be 1 in ONE and TWO; out_data SHALL be main in ONE and TWO, and NOP_VALUE in EMPTY.
REQ-017 in_ready SHALL be a registered signal, 1 in EMPTY and ONE and 0 in TWO, with no combinational path from out_ready.
REQ-018 From EMPTY, an input transfer SHALL load main and move to ONE.
REQ-019 From ONE:
- input with no output: load skid, move to TWO.
- input and output together: load main, stay in ONE.
- output only: move to EMPTY.
- neither: hold.
REQ-020 From TWO, an output transfer SHALL copy skid into main and move to ONE; otherwise the state SHALL hold.
REQ-021 Latency SHALL be one cycle: a payload accepted at edge N SHALL appear on out_data after edge N when the barrier was EMPTY, or ONE with a simultaneous output.
REQ-022 While out_valid && !out_ready, out_data SHALL remain stable until the output transfer.
REQ-023 Payloads SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush.
REQ-024 On an edge with flush=1:
- the next state SHALL be EMPTY regardless of in_valid or out_ready.
- any same-cycle input SHALL be discarded.
- in_ready SHALL be 1 in the following cycle.
REQ-025 flush SHALL take priority over every other transition.

Reset
REQ-026 On rst_n low, state SHALL go to EMPTY asynchronously, giving:
- out_valid=0
- out_data=NOP_VALUE
- in_ready=1
- main=skid=0
- stall_count=0
REQ-027 Reset deassertion SHALL take effect at the first rising clk edge with rst_n high; no transfer SHALL occur while rst_n is low.
REQ-028 Reset asserted mid-transfer SHALL discard held payloads identically to flush.

Configuration
REQ-029 With PIPELINE_BARRIER_STATS_EN defined, stall_count SHALL increment by 1 on every edge with out_valid && !out_ready && !flush.
REQ-030 With PIPELINE_BARRIER_STATS_EN defined, stall_count SHALL saturate at 16'hFFFF and SHALL be cleared only by reset.
REQ-031 Without PIPELINE_BARRIER_STATS_EN, the stall_count port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Stream: out_ready=1, in_valid=1, in_data=16'h1000..16'h1004 on consecutive edges -> out_data is 16'h1000..16'h1004 one cycle later each, and in_ready stays 1.
REQ-033 Backpressure: out_ready=0, accept 16'hAAAA then 16'hBBBB -> state TWO and in_ready=0; out_data holds 16'hAAAA; raise out_ready -> 16'hAAAA, then 16'hBBBB, then out_valid=0.
REQ-034 Flush: in state TWO, assert flush with in_valid=1 and in_data=16'hCCCC -> next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1, and 16'hCCCC never appears.
REQ-035 Reset mid-stream: drop rst_n asynchronously between edges while in ONE -> out_valid=0 immediately; after release, first accepted 16'h0042 emerges one cycle later.
REQ-036 Stats (macro defined): hold out_valid=1 with out_ready=0 for 70000 cycles -> stall_count=16'hFFFF and it does not wrap.
REQ-037 Stats (macro defined): a flush during a stall -> stall_count does not increment on that edge.
